// File: rtl/dbus_sram16_bridge.sv
// dbus_sram16_bridge: 32-bit dbus responder that runs each access as up to two
// 16-bit cycles on an external asynchronous x16 SRAM, stalling the CPU meanwhile.
module dbus_sram16_bridge #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dbus_address,
    input  logic [3:0]        dbus_byteenable,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [31:0]       dbus_wrdata,
    output logic [31:0]       dbus_rddata,
    output logic              dbus_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [3:0] W = 4'(WAIT_CYCLES);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              wr;
    logic [ADDR_W-2:0] addr;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic              req, phase, hi, last;
    logic              unused;

    assign req    = dbus_read | dbus_write;
    assign phase  = state == LO || state == HI;
    assign hi     = state == HI;
    assign last   = cnt == W;
    assign unused = ^{dbus_address[31:ADDR_W+1], dbus_address[1:0]};

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx   = state;
        dbus_stall = state == IDLE ? req : state != DONE;
        sram_addr  = {addr, hi};
        sram_dq_o  = hi ? wd[31:16] : wd[15:0];
        sram_dq_oe = phase & wr;
        sram_ce_n  = !phase;
        sram_oe_n  = !(phase & !wr);
        // with wait states the final cycle of a write phase holds address/data after we_n rises
        sram_we_n  = !(phase & wr & (W == 4'd0 || !last));
        sram_lb_n  = !(phase & (hi ? be[2] : be[0]));
        sram_ub_n  = !(phase & (hi ? be[3] : be[1]));
        case (state)
            IDLE:    if (req) state_nx = |dbus_byteenable[1:0] ? LO : |dbus_byteenable[3:2] ? HI : DONE;
            LO:      if (last) state_nx = |be[3:2] ? HI : DONE;
            HI:      if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt         <= '0;
            wr          <= 1'b0;
            addr        <= '0;
            be          <= '0;
            wd          <= '0;
            dbus_rddata <= '0;
        end else begin
            cnt <= (phase && !last) ? cnt + 4'd1 : 4'd0;
            if (state == IDLE && req) begin
                wr   <= dbus_write;
                addr <= dbus_address[ADDR_W:2];
                be   <= dbus_byteenable;
                wd   <= dbus_wrdata;
                if (!dbus_write) dbus_rddata <= '0;
            end
            if (state == LO && last && !wr) dbus_rddata[15:0]  <= sram_dq_i & {{8{be[1]}}, {8{be[0]}}};
            if (state == HI && last && !wr) dbus_rddata[31:16] <= sram_dq_i & {{8{be[3]}}, {8{be[2]}}};
        end
endmodule

// File: doc/dbus_sram16_bridge.md
# dbus_sram16_bridge

Data-bus responder for `naive_mips`: accepts 32-bit `dbus` read/write requests from the CPU and executes each one as up to two 16-bit cycles on an external asynchronous SRAM. It holds `dbus_stall` high until the access completes. It replaces the zero-latency behavioural `mem` model with a synthesizable path to a single x16 SRAM chip, and makes the CPU's stall handling observable.

## Interface
- `ADDR_W`, 18: SRAM halfword address width; byte space covered is 2^(ADDR_W+1).
- `WAIT_CYCLES`, 1: extra cycles per SRAM phase (W); legal range 0..15.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dbus_address`  in  32  byte address; bits [ADDR_W:2] are used.
- `dbus_byteenable`  in  4  lane enables; bit i maps to bits [8i+7:8i].
- `dbus_read`  in  1  read request; held stable by the CPU while stalled.
- `dbus_write`  in  1  write request; takes priority if both requests are high.
- `dbus_wrdata`  in  32  write data.
- `dbus_rddata`  out  32  registered read data; valid in the DONE cycle.
- `dbus_stall`  out  1  high while a request is outstanding.
- `sram_addr`  out  ADDR_W  halfword address {dbus_address[ADDR_W:2], half}.
- `sram_dq_o`  out  16  write data to SRAM.
- `sram_dq_oe`  out  1  drive enable for the external tristate.
- `sram_dq_i`  in  16  read data from SRAM.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n`  out  1 each  active-low SRAM controls.

## Operation
- States: IDLE, LO, HI, DONE. Phase counter is 4 bits.
- Request is `dbus_read | dbus_write`.
- **IDLE**
  - `dbus_stall = request`, combinational.
  - On a request, latch the operation, the address [ADDR_W:2], `dbus_byteenable` and `dbus_wrdata`.
  - Zero `dbus_rddata` if the operation is a read.
  - Next state: LO if be[1:0]≠0; else HI if be[3:2]≠0; else DONE.
- **LO / HI**
  - Each phase lasts W+1 cycles. The counter clears on entry and increments each cycle; the phase ends when counter==W.
  - `sram_addr` half bit is 0 in LO and 1 in HI.
  - `sram_lb_n`/`sram_ub_n` are the inverted latched be[0]/be[1] in LO and be[2]/be[3] in HI.
  - `sram_ce_n` is 0 throughout the phase.
  - Read phase: `sram_oe_n` is 0 for the whole phase. On the last cycle, capture `sram_dq_i` into `dbus_rddata` bits [15:0] (LO) or [31:16] (HI), enabled bytes only; disabled bytes stay 0.
  - Write phase:
    - `sram_dq_oe` is 1 and `sram_dq_o` carries latched wrdata [15:0] (LO) or [31:16] (HI).
    - If W≥1, `sram_we_n` is 0 for counter<W and 1 on the last cycle, giving one cycle of address/data hold.
    - If W=0, `sram_we_n` is 0 for the single cycle.
  - After LO: go to HI if be[3:2]≠0, else DONE. After HI: DONE.
- **DONE**
  - `dbus_stall = 0`, and all SRAM controls are inactive.
  - The CPU consumes `dbus_rddata` or retires the store at the next edge. Next state is IDLE.
  - A request seen in IDLE after DONE is always treated as a new access.
- Outside LO/HI: `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n` and `sram_ub_n` are 1, and `sram_dq_oe` is 0.
- SRAM control outputs depend only on registered state, never combinationally on `dbus_*`.

## Timing
- **Reset values**
  - State is IDLE, `dbus_rddata` is 0, `sram_addr` is 0, `sram_dq_o` is 0, `sram_dq_oe` is 0.
  - All active-low SRAM controls are 1.
  - `dbus_stall` follows the IDLE rule.
- **Stall duration** for a request arriving in cycle 0:
  - Both halves: stall is high for 2W+3 cycles; DONE is cycle 2W+3.
  - One half: stall is high for W+2 cycles.
  - be=0: stall is high for 1 cycle (IDLE→DONE). No SRAM activity occurs and read data is 0.
- **Reset mid-operation**: the block returns to IDLE immediately and asynchronously, and the SRAM controls deassert in the same instant. There are no partial-write retries.
- **Request changes while stalled**: the latched request is used, and the change is ignored until IDLE.
- **Address wrap**: dbus_address bits above ADDR_W are ignored, so addresses alias modulo 2^(ADDR_W+1).

## Test plan
- **Word write then read, W=1.**
  - Stimulus: write 0x80000010 ← 0xDEADBEEF with be=4'hF, then read the same address.
  - Expected: SRAM halfword 8 = 0xBEEF and halfword 9 = 0xDEAD; stall high for 5 cycles each; rddata = 0xDEADBEEF in DONE.
- **Byte write, W=0.**
  - Stimulus: write 0x12345678 to address 0x11 with be=4'b0010.
  - Expected: only a LO phase runs, with lb_n=1 and ub_n=0; stall is high for 2 cycles; a readback with be=4'hF returns 0x00005600 over the prior zeros.
- **Upper halfword read.**
  - Stimulus: be=4'b1100 on a word holding 0xCAFE0123.
  - Expected: only HI runs; rddata = 0xCAFE0000.
- **Empty byteenable.**
  - Stimulus: be=0 read.
  - Expected: 1 stall cycle; ce_n stays 1; rddata = 0.
- **Reset mid-write.**
  - Stimulus: assert rst during the LO phase of a word write.
  - Expected: we_n, ce_n and oe_n go to 1 and sram_dq_oe to 0 without waiting for a clock; the next request starts cleanly from IDLE.
- **Back-to-back.**
  - Stimulus: CPU loop test (inst_mem) with W=2.
  - Expected: register trace identical to the zero-wait `mem` model.
